// File: rtl/if_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// State encoding and PC mux select values.
package if_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } if_state_t;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_BR  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and sync clear.
// Clear wins over enable; never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // count up while enabled, stick at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: imem req/ready handshake, PC control,
// one-entry stall buffer and wrong-path squash.
module if_fetch_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              Br_taken,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic              PC_write,
  output logic              PC_src,
  output logic              IF_ID_flush,
  output logic [DATA_W-1:0] instruction,
  output logic              IF_valid,
  output logic [CNT_W-1:0]  fetch_stall_cnt,
  output logic              timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  if_state_t         state;
  if_state_t         state_nxt;
  logic [DATA_W-1:0] hold_buf;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;

  assign waiting = imem_req & ~imem_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_START;
    else     state <= state_nxt;
  end

  // next-state logic; branch beats stall
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_START: state_nxt = ST_REQ;
      ST_REQ: begin
        if (Br_taken)
          state_nxt = imem_ready ? ST_REQ : ST_DROP;
        else if (imem_ready && stall)
          state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (Br_taken || !stall)
          state_nxt = ST_REQ;
      end
      ST_DROP: begin
        if (imem_ready)
          state_nxt = ST_REQ;
      end
      default: state_nxt = ST_START;
    endcase
  end

  // PC control, flush and request outputs
  always_comb begin
    imem_req    = 1'b0;
    PC_write    = 1'b0;
    PC_src      = PC_SRC_SEQ;
    IF_ID_flush = 1'b0;
    unique case (state)
      ST_START: ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (Br_taken) begin
          PC_write    = 1'b1;
          PC_src      = PC_SRC_BR;
          IF_ID_flush = 1'b1;
        end else if (imem_ready && !stall) begin
          PC_write = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Br_taken) begin
          PC_write    = 1'b1;
          PC_src      = PC_SRC_BR;
          IF_ID_flush = 1'b1;
        end else if (!stall) begin
          PC_write = 1'b1;
        end
      end
      ST_DROP: begin
        imem_req = 1'b1;
        if (Br_taken) begin
          PC_write    = 1'b1;
          PC_src      = PC_SRC_BR;
          IF_ID_flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // instruction delivery and stall buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= '0;
      IF_valid    <= 1'b0;
      hold_buf    <= '0;
    end else begin
      unique case (state)
        ST_REQ: begin
          if (Br_taken) begin
            IF_valid <= 1'b0;
          end else if (imem_ready && !stall) begin
            instruction <= imem_rdata;
            IF_valid    <= 1'b1;
          end else if (imem_ready) begin
            hold_buf <= imem_rdata;
          end
        end
        ST_HOLD: begin
          if (Br_taken) begin
            IF_valid <= 1'b0;
          end else if (!stall) begin
            instruction <= hold_buf;
            IF_valid    <= 1'b1;
          end
        end
        ST_DROP: begin
          if (Br_taken) IF_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // sticky timeout once one request has waited MAX_WAIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timeout <= 1'b0;
    else if (wait_cnt >= WAIT_W'(MAX_WAIT))
      timeout <= 1'b1;
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .en  (waiting),
    .clr (imem_ready),
    .cnt (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (waiting),
    .clr (1'b0),
    .cnt (fetch_stall_cnt)
  );

endmodule
